// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] RV_NOP  = 32'h0000_0013;
  localparam logic [31:0] ARM_NOP = 32'hE1A0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] mode_nop(input logic arm);
    return arm ? ARM_NOP : RV_NOP;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction that Decode could not take.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload carries no reset; only the valid flag gives it meaning.
  always_ff @(posedge clk) begin
    if (load) begin
      entry <= load_entry;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC, single-outstanding instruction-memory requests and the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCRedirect,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlusD,
  output logic        ValidD,
  output logic        FetchWait
);

  logic         pend;
  logic         pend_kill;
  logic [31:0]  pend_pc;
  logic         free;
  logic         issue;
  logic         resp;
  logic         live;
  logic         d_load;
  logic         skid_load;
  logic         skid_drain;
  logic         skid_clear;
  logic         skid_v;
  fetch_entry_t skid_entry;
  fetch_entry_t resp_entry;

  // A response arriving this cycle frees the slot for a same-cycle issue.
  assign free       = ~pend | imem_rvalid;
  assign issue      = free & ~skid_v & ~StallF & ~PCRedirect;
  assign resp       = imem_rvalid & pend;
  assign live       = resp & ~pend_kill & ~PCRedirect & ~FlushD;
  assign d_load     = ~FlushD & ~StallD;
  assign skid_load  = live & (~d_load | skid_v);
  assign skid_drain = d_load & skid_v;
  assign skid_clear = FlushD | PCRedirect;
  assign resp_entry = '{pc: pend_pc, instr: imem_rdata};

  assign imem_req  = issue;
  assign imem_addr = PCF;
  assign FetchWait = pend & ~imem_rvalid;
  assign PCPlusD   = PCD + (arm ? 32'd8 : 32'd4);

  // Fetch PC and outstanding-request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF       <= RESET_PC;
      pend      <= 1'b0;
      pend_kill <= 1'b0;
    end else begin
      if (PCRedirect) begin
        PCF <= PCTarget;
      end else if (issue) begin
        PCF <= PCF + 32'd4;
      end

      if (issue) begin
        pend      <= 1'b1;
        pend_kill <= 1'b0;
      end else if (resp) begin
        pend      <= 1'b0;
        pend_kill <= 1'b0;
      end else if (PCRedirect && pend) begin
        pend_kill <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      pend_pc <= PCF;
    end
  end

  fetch_skid u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .load_entry (resp_entry),
    .valid      (skid_v),
    .entry      (skid_entry)
  );

  // IF/ID register: flush beats stall, skid beats a fresh response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidD <= 1'b0;
      InstrD <= mode_nop(arm);
      PCD    <= '0;
    end else if (FlushD) begin
      ValidD <= 1'b0;
      InstrD <= mode_nop(arm);
    end else if (!StallD) begin
      if (skid_v) begin
        ValidD <= 1'b1;
        PCD    <= skid_entry.pc;
        InstrD <= skid_entry.instr;
      end else if (live) begin
        ValidD <= 1'b1;
        PCD    <= pend_pc;
        InstrD <= imem_rdata;
      end else begin
        ValidD <= 1'b0;
        InstrD <= mode_nop(arm);
      end
    end
  end

endmodule
